data_bus_transmit: RTL and testbench
====================================

DATA_BUS_TRANSMIT -- requirements
Module: data_bus_transmit

Interface
REQ-001 SHALL have parameter SLOS_LEN, default 256, meaning total SLOS frame length in bytes, marker byte included.
REQ-002 SHALL have parameter PRBS_SEED, default 11'h400, meaning the PRBS11 generator reload value.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 lane_tx_on  input  1  transmit enable.
REQ-006 d_sel  input  4  pattern select: 0 SLOS1, 1 SLOS2, 2 Gen3 TS1, 3 Gen3 TS2, 4-7 Gen4 TS1-TS4, 8 data, 9-15 idle.
REQ-007 tl_data_in  input  8  transport-layer byte.
REQ-008 tl_valid  input  1  tl_data_in valid.
REQ-009 tl_ready  output  1  byte accepted this cycle when high with tl_valid.
REQ-010 lane_0_tx  output  8  lane 0 byte.
REQ-011 lane_1_tx  output  8  lane 1 byte.
REQ-012 data_os  output  1  1 = lanes carry data, 0 = ordered set or idle.
REQ-013 os_sent  output  1  one-cycle pulse with the last byte of each complete ordered set or SLOS frame.

Function
REQ-014 All outputs SHALL be registered, with one cycle of latency from the sampled inputs.
REQ-015 The FSM SHALL have states IDLE, SLOS, OS, DATA: IDLE->SLOS on d_sel 0/1, IDLE->OS on d_sel 2-7, IDLE->DATA on d_sel 8, any state->IDLE on d_sel 9-15 (at the frame boundary from SLOS/OS, per REQ-019).
REQ-016 Ordered sets SHALL be sent MSB byte first, one byte per cycle, and repeated back-to-back while d_sel is unchanged.
REQ-017 Gen3 TS SHALL be 8 bytes: TS1 64'h0100_0000_0400_98F2 on lane 0 and 64'h0101_0000_0400_98F2 on lane 1; TS2 64'h0100_0000_0400_64F2 on lane 0 and 64'h0101_0000_0400_64F2 on lane 1.
REQ-018 Gen4 TS SHALL be 4 bytes, identical on both lanes: TS1 32'h7E02_D0F0, TS2 32'h7E04_B0F0, TS3 32'h7E06_90F0, TS4 32'h7E0F_0F00.
REQ-019 A d_sel change mid-frame SHALL take effect only after the current frame's last byte; the new pattern starts at byte 0 on the next cycle.
REQ-020 SLOS1 frame SHALL be marker byte 0x40, then SLOS_LEN-1 PRBS11 bytes:
- x^11+x^9+1 Fibonacci LFSR, reloaded with PRBS_SEED at each frame start.
- Bits packed MSB first.
- Identical on both lanes.
REQ-021 SLOS2 SHALL be the bitwise inverse of SLOS1, so its marker byte is 0xBF.
REQ-022 The byte counter SHALL wrap to 0 after the last byte, and os_sent SHALL pulse in that same output cycle.
REQ-023 In DATA, tl_ready SHALL be 1; with tl_valid=1 both lanes SHALL carry tl_data_in and data_os=1.
REQ-024 In DATA with tl_valid=0, both lanes SHALL carry 0x00 and data_os=0.
REQ-025 tl_ready SHALL be 0 in every state other than DATA.
REQ-026 In IDLE, lanes SHALL be 0x00, with data_os=0 and os_sent=0.
REQ-027 lane_tx_on=0 SHALL force IDLE the next cycle regardless of frame position, and clear the byte counter and LFSR.

Reset
REQ-028 While rst=0:
- State=IDLE, byte counter=0, LFSR=PRBS_SEED.
- lane_0_tx=lane_1_tx=0x00; data_os, os_sent, tl_ready all 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release, transmission SHALL restart at byte 0 of the selected pattern.

Configuration
REQ-030 Macro DBT_GEN4_EN:
- Defined: d_sel 4-7 transmit Gen4 TS1-TS4.
- Undefined: the Gen4 tables and decode are removed, and d_sel 4-7 behave as idle (d_sel 9-15).

Verification
REQ-031 Reset, then lane_tx_on=1, d_sel=0 -> lane 0 first byte 0x40, then PRBS bytes; os_sent high on byte 256; the next frame restarts with 0x40.
REQ-032 d_sel=3 held -> lane 0 repeats 01,00,00,00,04,00,64,F2 and lane 1 repeats 01,01,00,00,04,00,64,F2; os_sent every 8th cycle.
REQ-033 With DBT_GEN4_EN defined, d_sel=5 -> 7E,04,B0,F0 repeating on both lanes; with it undefined -> 0x00 constant and os_sent=0.
REQ-034 d_sel 2->8 at Gen3 byte 3 -> bytes 4-7 of TS1 complete, then tl_data_in 0xA5 with tl_valid=1 appears on both lanes with data_os=1 and tl_ready=1.
REQ-035 lane_tx_on dropped mid-SLOS2 -> next cycle lanes 0x00; on re-enable, the first byte is 0xBF.
REQ-036 rst pulsed low mid Gen4 TS4 -> outputs 0x00 asynchronously; after release, restart at 0x7E.

Source files
------------

// File: rtl/data_bus_transmit.sv
// data_bus_transmit: two-lane transmitter for SLOS frames, Gen3/Gen4 training
// sequences and transport-layer data bytes. All outputs are registered one
// cycle after the inputs are sampled.
// Optional feature macro: DBT_GEN4_EN. When defined, d_sel 4-7 send Gen4 TS1-TS4.
// When undefined, the Gen4 tables are not built and d_sel 4-7 act as idle.
module data_bus_transmit #(
   parameter int          SLOS_LEN  = 256,
   parameter logic [10:0] PRBS_SEED = 11'h400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lane_tx_on,
   input  logic [3:0] d_sel,
   input  logic [7:0] tl_data_in,
   input  logic       tl_valid,
   output logic       tl_ready,
   output logic [7:0] lane_0_tx,
   output logic [7:0] lane_1_tx,
   output logic       data_os,
   output logic       os_sent
);

   localparam int CNT_W = (SLOS_LEN > 8) ? $clog2(SLOS_LEN) : 3;

   typedef enum logic [1:0] {ST_IDLE, ST_SLOS, ST_OS, ST_DATA} state_t;

   state_t           r_state, w_state_nxt, w_tgt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_len_m1;
   logic [10:0]      r_lfsr, w_lfsr_nxt, w_lfsr_adv;
   logic [3:0]       r_pat, w_pat_nxt, w_sel;
   logic             w_last;
   logic [7:0]       w_prbs, w_lane0, w_lane1;
   logic             w_data_os, w_os_sent, w_ready;

   // Eight steps of the x^11+x^9+1 Fibonacci LFSR; the first bit out lands in the byte MSB
   function automatic logic [18:0] prbs_step8(input logic [10:0] s);
      logic [10:0] v;
      logic [7:0]  b;
      v = s;
      b = '0;
      for (int i = 0; i < 8; i++) begin
         b = {b[6:0], v[10]};
         v = {v[9:0], v[10] ^ v[8]};
      end
      return {b, v};
   endfunction

   // Gen3 TS byte at position idx (MSB byte first); lane 1 differs only in the second byte
   function automatic logic [7:0] gen3_byte(input logic ts2, input logic lane1, input logic [2:0] idx);
      logic [63:0] v;
      logic [63:0] sh;
      v = ts2 ? 64'h0100_0000_0400_64F2 : 64'h0100_0000_0400_98F2;
      if (lane1) v[55:48] = 8'h01;
      sh = v >> (8 * (7 - int'(idx)));
      return sh[7:0];
   endfunction

`ifdef DBT_GEN4_EN
   // Gen4 TS byte at position idx (MSB byte first), same on both lanes
   function automatic logic [7:0] gen4_byte(input logic [1:0] ts, input logic [1:0] idx);
      logic [31:0] v;
      logic [31:0] sh;
      case (ts)
         2'd0:    v = 32'h7E02_D0F0;
         2'd1:    v = 32'h7E04_B0F0;
         2'd2:    v = 32'h7E06_90F0;
         default: v = 32'h7E0F_0F00;
      endcase
      sh = v >> (8 * (3 - int'(idx)));
      return sh[7:0];
   endfunction
`endif

   // Pattern in force this cycle: held mid-frame, otherwise taken live from d_sel
   always_comb begin
      w_sel    = ((r_state == ST_SLOS || r_state == ST_OS) && r_cnt != '0) ? r_pat : d_sel;
      w_tgt    = ST_IDLE;
      w_len_m1 = '0;
      case (w_sel)
         4'd0, 4'd1: begin
            w_tgt    = ST_SLOS;
            w_len_m1 = CNT_W'(SLOS_LEN - 1);
         end
         4'd2, 4'd3: begin
            w_tgt    = ST_OS;
            w_len_m1 = CNT_W'(7);
         end
`ifdef DBT_GEN4_EN
         4'd4, 4'd5, 4'd6, 4'd7: begin
            w_tgt    = ST_OS;
            w_len_m1 = CNT_W'(3);
         end
`endif
         4'd8:    w_tgt = ST_DATA;
         default: w_tgt = ST_IDLE;
      endcase
      w_last = (w_tgt == ST_SLOS || w_tgt == ST_OS) && (r_cnt == w_len_m1);
      {w_prbs, w_lfsr_adv} = prbs_step8(r_lfsr);
   end

   // State, byte counter and LFSR register; reset aborts any frame in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_lfsr  <= PRBS_SEED;
         r_pat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lfsr  <= w_lfsr_nxt;
         r_pat   <= w_pat_nxt;
      end
   end

   // Next state: advance within a frame, wrap on the last byte, drop to idle when the lane is off
   always_comb begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_lfsr_nxt  = PRBS_SEED;
      w_pat_nxt   = '0;
      if (lane_tx_on) begin
         w_state_nxt = w_tgt;
         w_pat_nxt   = w_sel;
         if ((w_tgt == ST_SLOS || w_tgt == ST_OS) && !w_last)
            w_cnt_nxt = r_cnt + 1'b1;
         // Marker byte leaves the LFSR at the seed so the first PRBS byte starts fresh
         if (w_tgt == ST_SLOS && r_cnt != '0)
            w_lfsr_nxt = w_lfsr_adv;
      end
   end

   // Output decode: byte for the current pattern position, or data / idle
   always_comb begin
      w_lane0   = '0;
      w_lane1   = '0;
      w_data_os = 1'b0;
      w_os_sent = 1'b0;
      w_ready   = 1'b0;
      if (lane_tx_on) begin
         case (w_tgt)
            ST_SLOS: begin
               w_lane0 = (r_cnt == '0) ? 8'h40 : w_prbs;
               if (w_sel[0]) w_lane0 = ~w_lane0;
               w_lane1   = w_lane0;
               w_os_sent = w_last;
            end
            ST_OS: begin
`ifdef DBT_GEN4_EN
               if (w_sel[2]) begin
                  w_lane0 = gen4_byte(w_sel[1:0], r_cnt[1:0]);
                  w_lane1 = w_lane0;
               end else
`endif
               begin
                  w_lane0 = gen3_byte(w_sel[0], 1'b0, r_cnt[2:0]);
                  w_lane1 = gen3_byte(w_sel[0], 1'b1, r_cnt[2:0]);
               end
               w_os_sent = w_last;
            end
            ST_DATA: begin
               w_ready = 1'b1;
               if (tl_valid) begin
                  w_lane0   = tl_data_in;
                  w_lane1   = tl_data_in;
                  w_data_os = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_0_tx <= '0;
         lane_1_tx <= '0;
         data_os   <= 1'b0;
         os_sent   <= 1'b0;
         tl_ready  <= 1'b0;
      end else begin
         lane_0_tx <= w_lane0;
         lane_1_tx <= w_lane1;
         data_os   <= w_data_os;
         os_sent   <= w_os_sent;
         tl_ready  <= w_ready;
      end
   end

endmodule

// File: tb/tb_data_bus_transmit.sv
// Bench for data_bus_transmit: directed steps plus randomized traffic, checked
// against a frame-queue reference model. Honours DBT_GEN4_EN like the design.
module tb_data_bus_transmit;
   localparam int          SLOS_LEN  = 256;
   localparam logic [10:0] PRBS_SEED = 11'h400;

   logic       clk = 1'b0;
   logic       rst, lane_tx_on, tl_valid, tl_ready, data_os, os_sent;
   logic [3:0] d_sel;
   logic [7:0] tl_data_in, lane_0_tx, lane_1_tx;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] slos1 [SLOS_LEN];
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   logic [7:0] e0, e1;
   logic       edos, eos, erdy;

   logic [7:0] ts1_l0 [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h98, 8'hF2};
   logic [7:0] ts2_l0 [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h64, 8'hF2};
   logic [7:0] ts2_l1 [8] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h64, 8'hF2};
   logic [7:0] g4ts2  [4] = '{8'h7E, 8'h04, 8'hB0, 8'hF0};

   data_bus_transmit #(.SLOS_LEN(SLOS_LEN), .PRBS_SEED(PRBS_SEED)) dut (
      .clk        (clk),
      .rst        (rst),
      .lane_tx_on (lane_tx_on),
      .d_sel      (d_sel),
      .tl_data_in (tl_data_in),
      .tl_valid   (tl_valid),
      .tl_ready   (tl_ready),
      .lane_0_tx  (lane_0_tx),
      .lane_1_tx  (lane_1_tx),
      .data_os    (data_os),
      .os_sent    (os_sent)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: whole frames are queued when the previous one has drained
   task automatic model(input logic lto, input logic [3:0] sel, input logic [7:0] d, input logic v);
      logic [63:0] t0, t1;
      logic [31:0] g;
      {e0, e1, edos, eos, erdy} = '0;
      if (!lto) begin
         q0.delete();
         q1.delete();
         return;
      end
      if (q0.size() == 0) begin
         if (sel <= 4'd1) begin
            for (int k = 0; k < SLOS_LEN; k++) begin
               q0.push_back(sel[0] ? ~slos1[k] : slos1[k]);
               q1.push_back(sel[0] ? ~slos1[k] : slos1[k]);
            end
         end else if (sel <= 4'd3) begin
            t0 = sel[0] ? 64'h0100_0000_0400_64F2 : 64'h0100_0000_0400_98F2;
            t1 = t0 | 64'h0001_0000_0000_0000;
            for (int k = 0; k < 8; k++) begin
               q0.push_back(t0[63-8*k -: 8]);
               q1.push_back(t1[63-8*k -: 8]);
            end
         end
`ifdef DBT_GEN4_EN
         else if (sel <= 4'd7) begin
            case (sel)
               4'd4:    g = 32'h7E02_D0F0;
               4'd5:    g = 32'h7E04_B0F0;
               4'd6:    g = 32'h7E06_90F0;
               default: g = 32'h7E0F_0F00;
            endcase
            for (int k = 0; k < 4; k++) begin
               q0.push_back(g[31-8*k -: 8]);
               q1.push_back(g[31-8*k -: 8]);
            end
         end
`endif
         else if (sel == 4'd8) begin
            erdy = 1'b1;
            edos = v;
            if (v) begin
               e0 = d;
               e1 = d;
            end
         end
      end
      if (q0.size() != 0) begin
         e0  = q0.pop_front();
         e1  = q1.pop_front();
         eos = (q0.size() == 0);
      end
   endtask

   // One clock: drive at the falling edge, check 1 time unit after the rising edge
   task automatic cyc(input string tag, input logic lto, input logic [3:0] sel,
                      input logic [7:0] d, input logic v);
      @(negedge clk);
      lane_tx_on = lto;
      d_sel      = sel;
      tl_data_in = d;
      tl_valid   = v;
      model(lto, sel, d, v);
      @(posedge clk);
      #1;
      chk(tag, {13'd0, lane_0_tx, lane_1_tx, data_os, os_sent, tl_ready},
               {13'd0, e0, e1, edos, eos, erdy});
   endtask

   task automatic reset_pulse();
      #1 rst = 1'b0;
      #1;
      q0.delete();
      q1.delete();
      chk("async_reset_outputs", {13'd0, lane_0_tx, lane_1_tx, data_os, os_sent, tl_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      int s, b;
      s = int'(PRBS_SEED);
      slos1[0] = 8'h40;
      for (int k = 1; k < SLOS_LEN; k++) begin
         b = 0;
         for (int j = 0; j < 8; j++) begin
            b = (b << 1) | ((s >> 10) & 1);
            s = ((s << 1) | (((s >> 10) ^ (s >> 8)) & 1)) & 'h7FF;
         end
         slos1[k] = 8'(b);
      end

      rst = 1'b0; lane_tx_on = 1'b0; d_sel = 4'hF; tl_data_in = 8'h00; tl_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {13'd0, lane_0_tx, lane_1_tx, data_os, os_sent, tl_ready}, 32'd0);
      #1 rst = 1'b1;

      // SLOS1 frame, its last byte, and the restart
      cyc("slos1", 1'b1, 4'd0, 8'($urandom), 1'($urandom));
      chk("slos1_marker", {24'd0, lane_0_tx}, 32'h40);
      for (int k = 1; k < SLOS_LEN; k++) cyc("slos1", 1'b1, 4'd0, 8'($urandom), 1'($urandom));
      chk("slos1_os_sent_last", {31'd0, os_sent}, 32'd1);
      cyc("slos1", 1'b1, 4'd0, 8'h00, 1'b0);
      chk("slos1_restart", {24'd0, lane_0_tx}, 32'h40);
      for (int k = 0; k < SLOS_LEN && q0.size() != 0; k++)
         cyc("slos1_drain", 1'b1, 4'd3, 8'($urandom), 1'($urandom));

      // Gen3 TS2 held
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 8; k++) begin
            cyc("gen3_ts2", 1'b1, 4'd3, 8'($urandom), 1'($urandom));
            chk("ts2_lane0", {24'd0, lane_0_tx}, {24'd0, ts2_l0[k]});
            chk("ts2_lane1", {24'd0, lane_1_tx}, {24'd0, ts2_l1[k]});
            chk("ts2_os_sent", {31'd0, os_sent}, {31'd0, (k == 7)});
         end
      end

      // Gen4 TS2 (or idle when Gen4 is compiled out)
      for (int k = 0; k < 8; k++) begin
         cyc("gen4_ts2", 1'b1, 4'd5, 8'($urandom), 1'($urandom));
`ifdef DBT_GEN4_EN
         chk("gen4_ts2_lanes", {16'd0, lane_0_tx, lane_1_tx}, {16'd0, g4ts2[k%4], g4ts2[k%4]});
         chk("gen4_ts2_os_sent", {31'd0, os_sent}, {31'd0, (k % 4 == 3)});
`else
         chk("gen4_off_quiet", {15'd0, lane_0_tx, lane_1_tx, os_sent}, 32'd0);
`endif
      end

      // TS1 interrupted by a switch to data at byte 3
      for (int k = 0; k < 4; k++) cyc("ts1_head", 1'b1, 4'd2, 8'($urandom), 1'($urandom));
      for (int k = 0; k < 4; k++) begin
         cyc("ts1_tail", 1'b1, 4'd8, 8'hA5, 1'b1);
         chk("ts1_tail_lane0", {24'd0, lane_0_tx}, {24'd0, ts1_l0[k+4]});
         chk("ts1_tail_not_ready", {31'd0, tl_ready}, 32'd0);
      end
      cyc("data_a5", 1'b1, 4'd8, 8'hA5, 1'b1);
      chk("data_a5", {14'd0, lane_0_tx, lane_1_tx, data_os, tl_ready}, {14'd0, 8'hA5, 8'hA5, 1'b1, 1'b1});
      cyc("data_novalid", 1'b1, 4'd8, 8'h3C, 1'b0);
      chk("data_novalid", {14'd0, lane_0_tx, lane_1_tx, data_os, tl_ready}, {14'd0, 16'h0000, 1'b0, 1'b1});
      for (int k = 0; k < 20; k++) cyc("data_rand", 1'b1, 4'd8, 8'($urandom), 1'($urandom));

      // SLOS2 interrupted by lane_tx_on low
      for (int k = 0; k < 10; k++) cyc("slos2", 1'b1, 4'd1, 8'($urandom), 1'($urandom));
      cyc("slos2_off", 1'b0, 4'd1, 8'h00, 1'b0);
      chk("slos2_off_lanes", {16'd0, lane_0_tx, lane_1_tx}, 32'd0);
      cyc("slos2_reenable", 1'b1, 4'd1, 8'h00, 1'b0);
      chk("slos2_marker", {16'd0, lane_0_tx, lane_1_tx}, 32'hBFBF);
      for (int k = 0; k < SLOS_LEN && q0.size() != 0; k++)
         cyc("slos2_drain", 1'b1, 4'd7, 8'($urandom), 1'($urandom));

      // Asynchronous reset mid Gen4 TS4, then mid Gen3 TS1
      for (int k = 0; k < 6; k++) cyc("gen4_ts4", 1'b1, 4'd7, 8'($urandom), 1'($urandom));
      reset_pulse();
      cyc("after_reset_ts4", 1'b1, 4'd7, 8'h00, 1'b0);
`ifdef DBT_GEN4_EN
      chk("ts4_restart", {24'd0, lane_0_tx}, 32'h7E);
`else
      chk("ts4_off_restart", {24'd0, lane_0_tx}, 32'h00);
`endif
      for (int k = 0; k < 3; k++) cyc("gen3_ts1", 1'b1, 4'd2, 8'($urandom), 1'($urandom));
      reset_pulse();
      cyc("after_reset_ts1", 1'b1, 4'd2, 8'h00, 1'b0);
      chk("ts1_restart", {16'd0, lane_0_tx, lane_1_tx}, 32'h0101);

      // Randomized traffic
      for (int blk = 0; blk < 120; blk++) begin
         logic [3:0] rs;
         int         len;
         rs  = 4'($urandom_range(0, 15));
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++)
            cyc("random", ($urandom_range(0, 15) != 0), rs, 8'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
